// File: rtl/ccl_labeler_stream.sv
// Streaming first-pass connected-component labeler: raster-order mask in, labels/allocations/merges out.
// Optional macro CCL_CONN8_EN selects 8-connectivity; default build is 4-connectivity.
module ccl_labeler_stream #(
  parameter int LABEL_WIDTH = 8,
  parameter int IMG_WIDTH   = 320,
  parameter int IMG_HEIGHT  = 240,
  parameter int COL_W       = $clog2(IMG_WIDTH),
  parameter int ROW_W       = $clog2(IMG_HEIGHT)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_enable,
  input  logic                   i_sof,
  input  logic                   i_motion_pixel,
  output logic                   o_label_valid,
  output logic [LABEL_WIDTH-1:0] o_current_label,
  output logic                   o_new_label_valid,
  output logic [LABEL_WIDTH-1:0] o_new_label_value,
  output logic                   o_merge_labels,
  output logic [LABEL_WIDTH-1:0] o_merge_a,
  output logic [LABEL_WIDTH-1:0] o_merge_b,
  output logic                   o_labels_full,
  output logic                   o_eof
);

`ifdef CCL_CONN8_EN
  localparam int NB = 4;
`else
  localparam int NB = 2;
`endif
  localparam logic [LABEL_WIDTH-1:0] LMAX = '1;

  logic [LABEL_WIDTH-1:0] r_lbuf [IMG_WIDTH];
  logic [COL_W-1:0]       r_col;
  logic [ROW_W-1:0]       r_row;
  logic [LABEL_WIDTH-1:0] r_next;
  logic [LABEL_WIDTH-1:0] r_left;
  logic                   r_full;
  logic                   r_active;

  logic                   w_pix, w_full, w_first_row, w_first_col, w_last_col, w_last_row;
  logic [COL_W-1:0]       w_col;
  logic [ROW_W-1:0]       w_row;
  logic [LABEL_WIDTH-1:0] w_next, w_top_raw, w_top, w_left, w_mn, w_mx, w_label;
  logic [NB-1:0][LABEL_WIDTH-1:0] w_nb;
  logic                   w_new, w_merge;

  // sof overrides the frame state for its own pixel so it always lands at (0,0) with a fresh allocator
  assign w_pix       = i_enable & (i_sof | r_active);
  assign w_col       = i_sof ? '0 : r_col;
  assign w_row       = i_sof ? '0 : r_row;
  assign w_next      = i_sof ? LABEL_WIDTH'(1) : r_next;
  assign w_full      = i_sof ? 1'b0 : r_full;
  assign w_first_row = (w_row == '0);
  assign w_first_col = (w_col == '0);
  assign w_last_col  = (w_col == COL_W'(IMG_WIDTH - 1));
  assign w_last_row  = (w_row == ROW_W'(IMG_HEIGHT - 1));

  assign w_top_raw = r_lbuf[w_col];
  assign w_top     = w_first_row ? '0 : w_top_raw;
  assign w_left    = w_first_col ? '0 : r_left;

`ifdef CCL_CONN8_EN
  logic [LABEL_WIDTH-1:0] r_tl;
  logic [COL_W-1:0]       w_col_nx;
  // top-left was overwritten by the previous pixel, so it is carried in r_tl
  assign w_col_nx = w_last_col ? w_col : w_col + COL_W'(1);
  assign w_nb[0]  = w_left;
  assign w_nb[1]  = w_top;
  assign w_nb[2]  = (w_first_row | w_first_col) ? '0 : r_tl;
  assign w_nb[3]  = (w_first_row | w_last_col) ? '0 : r_lbuf[w_col_nx];
`else
  assign w_nb[0]  = w_left;
  assign w_nb[1]  = w_top;
`endif

  always_comb begin
    w_mn = '0;
    w_mx = '0;
    for (int i = 0; i < NB; i++) begin
      if (w_nb[i] != '0) begin
        if (w_mn == '0 || w_nb[i] < w_mn) w_mn = w_nb[i];
        if (w_nb[i] > w_mx) w_mx = w_nb[i];
      end
    end
  end

  always_comb begin
    w_label = '0;
    w_new   = 1'b0;
    w_merge = 1'b0;
    if (i_motion_pixel) begin
      if (w_mx == '0) begin
        if (!w_full) begin
          w_label = w_next;
          w_new   = 1'b1;
        end
      end else begin
        w_label = w_mn;
        w_merge = (w_mn != w_mx);
      end
    end
  end

  // line buffer is deliberately not reset; row 0 masks stale contents
  always_ff @(posedge i_clk) begin
    if (i_rst && w_pix) r_lbuf[w_col] <= w_label;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_col             <= '0;
      r_row             <= '0;
      r_next            <= LABEL_WIDTH'(1);
      r_left            <= '0;
      r_full            <= 1'b0;
      r_active          <= 1'b0;
      o_label_valid     <= 1'b0;
      o_current_label   <= '0;
      o_new_label_valid <= 1'b0;
      o_new_label_value <= '0;
      o_merge_labels    <= 1'b0;
      o_merge_a         <= '0;
      o_merge_b         <= '0;
      o_labels_full     <= 1'b0;
      o_eof             <= 1'b0;
`ifdef CCL_CONN8_EN
      r_tl              <= '0;
`endif
    end else begin
      o_label_valid     <= w_pix;
      o_current_label   <= '0;
      o_new_label_valid <= 1'b0;
      o_new_label_value <= '0;
      o_merge_labels    <= 1'b0;
      o_merge_a         <= '0;
      o_merge_b         <= '0;
      o_eof             <= 1'b0;
      o_labels_full     <= r_full;
      if (w_pix) begin
        o_current_label   <= w_label;
        o_new_label_valid <= w_new;
        o_new_label_value <= w_new ? w_label : '0;
        o_merge_labels    <= w_merge;
        o_merge_a         <= w_merge ? w_mn : '0;
        o_merge_b         <= w_merge ? w_mx : '0;
        o_labels_full     <= w_full | (w_new && w_next == LMAX);
        r_full            <= w_full | (w_new && w_next == LMAX);
        r_next            <= w_new ? w_next + LABEL_WIDTH'(1) : w_next;
        r_left            <= w_label;
        r_active          <= 1'b1;
`ifdef CCL_CONN8_EN
        r_tl              <= w_top_raw;
`endif
        if (w_last_col) begin
          r_col <= '0;
          if (w_last_row) begin
            r_row    <= '0;
            r_active <= 1'b0;
            o_eof    <= 1'b1;
          end else begin
            r_row <= w_row + ROW_W'(1);
          end
        end else begin
          r_col <= w_col + COL_W'(1);
          r_row <= w_row;
        end
      end
    end
  end

endmodule
